pattern_sequencer: RTL and testbench

PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

---
 rtl/pattern_sequencer.sv | 115 +++++++++++
 tb/tb_pattern_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: plays a range of pattern words from a single-port BRAM onto led at a programmable step rate.
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_start, cmd_stop           start/stop pulses; start_addr, end_addr, loop_en, div sampled on an accepted start
//   wr_req, wr_addr, wr_data      loader write request, granted via wr_ack when the port is free
//   mem_en, mem_we, mem_addr,     BRAM port; playback reads take priority over loader writes
//   mem_wdata, mem_rdata
//   led, busy, done, cfg_err      pattern output and status
module pattern_sequencer #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 5,
   parameter int DIV_W  = 25
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_start,
   input  logic              cmd_stop,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] end_addr,
   input  logic              loop_en,
   input  logic [DIV_W-1:0]  div,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] led,
   output logic              busy,
   output logic              done,
   output logic              cfg_err
);
   typedef enum logic [2:0] {IDLE, FETCH, LATCH, WAIT, DONE} state_t;
   state_t state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, sa_q, sa_d, ea_q, ea_d;
   logic              loop_q, loop_d;
   logic [DIV_W-1:0]  div_q, div_d, cnt_q, cnt_d;
   logic [DATA_W-1:0] led_q, led_d;
   logic              cfg_err_q, cfg_err_d;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      sa_d      = sa_q;
      ea_d      = ea_q;
      loop_d    = loop_q;
      div_d     = div_q;
      cnt_d     = cnt_q;
      led_d     = led_q;
      cfg_err_d = 1'b0;
      // stop preempts every state action, including a pending LATCH
      if (cmd_stop && state_q != IDLE) state_d = IDLE;
      else case (state_q)
         IDLE: if (cmd_start && !cmd_stop) begin
            if (start_addr <= end_addr) begin
               state_d = FETCH;
               pc_d    = start_addr;
               sa_d    = start_addr;
               ea_d    = end_addr;
               loop_d  = loop_en;
               div_d   = div;
            end else cfg_err_d = 1'b1;
         end
         FETCH: state_d = LATCH;
         LATCH: begin
            led_d = mem_rdata;
            if (pc_q != ea_q || loop_q) begin
               pc_d    = pc_q != ea_q ? pc_q + 1'b1 : sa_q;
               cnt_d   = div_q;
               state_d = WAIT;
            end else state_d = DONE;
         end
         WAIT: if (cnt_q == '0) state_d = FETCH;
               else cnt_d = cnt_q - 1'b1;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         sa_q      <= '0;
         ea_q      <= '0;
         loop_q    <= 1'b0;
         div_q     <= '0;
         cnt_q     <= '0;
         led_q     <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         sa_q      <= sa_d;
         ea_q      <= ea_d;
         loop_q    <= loop_d;
         div_q     <= div_d;
         cnt_q     <= cnt_d;
         led_q     <= led_d;
         cfg_err_q <= cfg_err_d;
      end

   // rst gates the grant so a held wr_req cannot reach the BRAM during reset
   assign wr_ack    = wr_req && state_q != FETCH && !rst;
   assign mem_en    = state_q == FETCH || wr_ack;
   assign mem_we    = wr_ack;
   assign mem_addr  = state_q == FETCH ? pc_q : wr_addr;
   assign mem_wdata = wr_data;
   assign led       = led_q;
   assign busy      = state_q != IDLE;
   assign done      = state_q == DONE && !cmd_stop;
   assign cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: self-checking bench with a BRAM model and a timing-formula reference.
module tb_pattern_sequencer;
   logic        clk = 1'b0, rst = 1'b1;
   logic        cmd_start = 0, cmd_stop = 0, loop_en = 0, wr_req = 0;
   logic [4:0]  start_addr = 0, end_addr = 0, wr_addr = 0, wr_data = 0;
   logic [24:0] div = 0;
   logic        wr_ack, mem_en, mem_we, busy, done, cfg_err;
   logic [4:0]  mem_addr, mem_wdata, mem_rdata, led;
   logic [4:0]  bram [0:31];
   logic [4:0]  ref_mem [0:31];
   logic [4:0]  exp_led = 0;
   int          n_cmp = 0, n_err = 0;

   pattern_sequencer dut (
      .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
      .start_addr(start_addr), .end_addr(end_addr), .loop_en(loop_en), .div(div),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .led(led), .busy(busy), .done(done), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (mem_en) begin
         if (mem_we) bram[mem_addr] <= mem_wdata;
         else mem_rdata <= bram[mem_addr];
      end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load(input int a, input int d);
      @(negedge clk);
      wr_req = 1; wr_addr = a[4:0]; wr_data = d[4:0];
      #1;
      chk("load_ack", wr_ack, 1);
      chk("load_we", mem_we, 1);
      chk("load_addr", mem_addr, a);
      ref_mem[a] = d[4:0];
      @(negedge clk);
      wr_req = 0;
   endtask

   // Window j is the clock period after the j-th edge following the start pulse.
   // Step k fetches in window k*p, latches in k*p+1 and led shows the word from window k*p+2.
   task automatic play(input int sa, input int ea, input bit lp, input int dv,
                       input int ncyc_loop, input int wr_at, input int ign_at);
      int p, n, jl, ncyc, wa, wd, k;
      bit pend, fetch, ack, bsy;
      p = dv + 3; n = ea - sa + 1; jl = (n - 1) * p + 2;
      ncyc = lp ? ncyc_loop : jl + 2;
      wa = (ea + 1) % 32; wd = $urandom_range(0, 31); pend = 0;
      @(negedge clk);
      cmd_start = 1; start_addr = sa[4:0]; end_addr = ea[4:0]; loop_en = lp; div = dv[24:0];
      #1 chk("idle_mem_en", mem_en, 0);
      for (int j = 0; j <= ncyc; j++) begin
         @(negedge clk);
         bsy = lp ? (j < ncyc) : (j <= jl);
         if (j >= 2 && (j - 2) % p == 0 && (lp ? j < ncyc : j <= jl)) begin
            k = (j - 2) / p;
            exp_led = ref_mem[sa + k % n];
         end
         chk("led", led, exp_led);
         chk("busy", busy, bsy);
         chk("done", done, !lp && j == jl);
         chk("cfg_err_busy", cfg_err, 0);
         cmd_start = 0;
         cmd_stop = lp && j == ncyc - 1;
         if (j == wr_at) begin pend = 1; wr_addr = wa[4:0]; wr_data = wd[4:0]; end
         wr_req = pend;
         if (j == ign_at) begin cmd_start = 1; start_addr = 31; end_addr = 0; end
         fetch = bsy && j % p == 0 && (lp || j <= jl - 2);
         ack = pend && !fetch;
         #1;
         chk("wr_ack", wr_ack, ack);
         chk("mem_en", mem_en, fetch || ack);
         chk("mem_we", mem_we, ack);
         if (fetch) chk("fetch_addr", mem_addr, sa + (j / p) % n);
         else if (ack) chk("wr_addr", mem_addr, wa);
         if (ack) begin ref_mem[wa] = wd[4:0]; pend = 0; end
      end
      cmd_start = 0; cmd_stop = 0; wr_req = 0;
   endtask

   initial begin
      int sa, ea, dv, nc;
      bit lp;
      wr_req = 1;
      #12;
      chk("rst_led", led, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_wr_ack", wr_ack, 0);
      wr_req = 0;
      @(posedge clk); #2 rst = 0;
      for (int a = 0; a < 32; a++) load(a, $urandom_range(0, 31));
      load(0, 'h1F); load(1, 'h06); load(2, 'h1F); load(3, 'h05);
      play(0, 3, 0, 2, 0, -1, -1);
      play(0, 1, 1, 0, 11, 4, 5);
      // rejected start, then start and stop together while idle
      @(negedge clk);
      cmd_start = 1; start_addr = 4; end_addr = 2;
      @(negedge clk);
      chk("rej_cfg_err", cfg_err, 1);
      chk("rej_busy", busy, 0);
      cmd_start = 0;
      @(negedge clk);
      chk("rej_cfg_err_clr", cfg_err, 0);
      chk("rej_busy2", busy, 0);
      cmd_start = 1; cmd_stop = 1;
      @(negedge clk);
      chk("ss_bad_cfg_err", cfg_err, 0);
      chk("ss_bad_busy", busy, 0);
      start_addr = 0; end_addr = 3;
      @(negedge clk);
      chk("ss_good_busy", busy, 0);
      chk("ss_good_cfg_err", cfg_err, 0);
      cmd_start = 0; cmd_stop = 0;
      @(negedge clk);
      chk("ss_busy", busy, 0);
      chk("ss_led", led, exp_led);
      for (int r = 0; r < 8; r++) begin
         sa = $urandom_range(0, 28); ea = sa + $urandom_range(0, 3);
         lp = 1'($urandom_range(0, 1)); dv = $urandom_range(0, 3);
         nc = $urandom_range(6, 20);
         play(sa, ea, lp, dv, nc, $urandom_range(0, 1), $urandom_range(0, 2));
         load($urandom_range(0, 31), $urandom_range(0, 31));
      end
      // asynchronous reset while in WAIT
      @(negedge clk);
      cmd_start = 1; start_addr = 0; end_addr = 3; loop_en = 0; div = 2;
      @(negedge clk); cmd_start = 0;
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1; wr_req = 1;
      #1;
      exp_led = 0;
      chk("arst_led", led, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_cfg_err", cfg_err, 0);
      chk("arst_mem_en", mem_en, 0);
      chk("arst_mem_we", mem_we, 0);
      chk("arst_wr_ack", wr_ack, 0);
      @(posedge clk); #2 rst = 0; wr_req = 0;
      play(31, 31, 0, 0, 0, -1, -1);
      play(30, 31, 1, 1, 14, 3, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
